dot_game_sequencer: RTL and testbench
=====================================

DOT_GAME_SEQUENCER -- requirements
Module: dot_game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000: clk cycles per obstacle scroll step, legal range 2..2^32-1.
REQ-002 Parameter FLASH_CYCLES, default 50000000: clk cycles spent in HIT, legal range 1..2^32-1.
REQ-003 Parameter LIVES, default 3: lives granted per game, legal range 1..3.
REQ-004 clk  in  1  system clock, all state on posedge clk.
REQ-005 rst  in  1  reset: asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse, already debounced; begins or restarts a game.
REQ-007 up_req  in  1  one-cycle pulse, already debounced; move player one row up.
REQ-008 down_req  in  1  one-cycle pulse, already debounced; move player one row down.
REQ-009 obstacle_col  in  8  obstacle occupancy of the player column, bit r = row r lit; row 0 = top.
REQ-010 scroll_en  out  1  one-cycle pulse: datapath shifts obstacles one column.
REQ-011 board_clear  out  1  one-cycle pulse: datapath reloads its initial obstacle pattern.
REQ-012 player_row  out  3  top row of the 2-row player sprite, range 0..6.
REQ-013 blank  out  1  display blanking, high while in HIT.
REQ-014 score  out  8  scroll steps survived in the current game, saturating.
REQ-015 lives  out  2  remaining lives.
REQ-016 game_over  out  1  high while in OVER.
REQ-017 state  out  2  encoding: IDLE=0, PLAY=1, HIT=2, OVER=3.

Function
REQ-018 FSM IDLE: all pulses low; start -> PLAY.
REQ-019 IDLE->PLAY and OVER->PLAY (on start) set score=0, lives=LIVES, player_row=3, tick counter=0, and pulse board_clear in the transition cycle.
REQ-020 PLAY tick counter: counts 0..TICK_DIV-1 and wraps to 0.
REQ-021 PLAY scroll: scroll_en is high for exactly the one cycle in which the counter equals TICK_DIV-1.
REQ-022 PLAY score: score += 1 on every scroll_en cycle, holding at 255 with no wrap.
REQ-023 PLAY movement, up: up_req alone decrements player_row, clamped at 0.
REQ-024 PLAY movement, down: down_req alone increments player_row, clamped at 6.
REQ-025 PLAY movement, conflicts: up_req and down_req high in the same cycle, or requests in any state other than PLAY, are ignored.
REQ-026 Collision detect: in PLAY, collision = obstacle_col[player_row] | obstacle_col[player_row+1], using the registered player_row, evaluated every cycle.
REQ-027 Collision priority: a collision overrides scroll and move updates in the same cycle, so score and player_row hold.
REQ-028 Collision transition: collision in PLAY -> HIT next cycle; lives decrements by 1 on entry; flash counter = 0.
REQ-029 HIT: blank=1; flash counter counts to FLASH_CYCLES-1, then:
  - if lives==0 -> OVER;
  - else -> PLAY with board_clear pulsed in the exit cycle, tick counter=0, player_row=3, score kept.
REQ-030 OVER: game_over=1; score and lives frozen; start -> PLAY per REQ-019.
REQ-031 start in PLAY or HIT: immediate restart per REQ-019, discarding any pending collision or flash in progress.
REQ-032 All outputs are registered, except that state, blank and game_over may be decoded directly from the state register.

Reset
REQ-033 Reset values: state=IDLE, scroll_en=0, board_clear=0, player_row=3, blank=0, score=0, lives=LIVES, game_over=0, all counters 0.
REQ-034 Reset asserted mid-game forces the reset values immediately, with no trailing pulses; the first active edge after release evaluates from IDLE.

Verification (TICK_DIV=4, FLASH_CYCLES=3, LIVES=2, obstacle_col=0 unless stated)
REQ-035 Start and scroll: reset, then start pulse -> board_clear 1 cycle, state=1; scroll_en every 4th cycle; score=5 after 5 pulses.
REQ-036 Clamping: in PLAY, 5 up_req pulses -> player_row 3,2,1,0,0,0; simultaneous up_req+down_req -> player_row unchanged.
REQ-037 Hit with lives left: player_row=3, obstacle_col=8'h10 -> state=2 next cycle, lives=1, blank=1 for 3 cycles; then state=1 with board_clear pulse and score retained.
REQ-038 Game over and restart: a second collision -> lives=0, HIT for 3 cycles, then state=3 with game_over=1; start -> state=1, score=0, lives=2.
REQ-039 Scroll/collision/saturation: collision on a scroll_en cycle -> score not incremented; score forced to 254 then two scrolls -> 255, 255.
REQ-040 Reset mid-game: rst low during HIT -> all outputs at REQ-033 values in the same cycle, with no board_clear after release.

Source files
------------

// File: rtl/dot_game_sequencer.sv
// Game controller for the scrolling dot-dodge display: sequences IDLE/PLAY/HIT/OVER,
// paces obstacle scrolling, tracks player row, score and lives, and detects collisions.
module dot_game_sequencer #(
    parameter int unsigned TICK_DIV     = 25000000,
    parameter int unsigned FLASH_CYCLES = 50000000,
    parameter int unsigned LIVES        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       up_req,
    input  logic       down_req,
    input  logic [7:0] obstacle_col,
    output logic       scroll_en,
    output logic       board_clear,
    output logic [2:0] player_row,
    output logic       blank,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_HIT  = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
    localparam logic [31:0] FLASH_LAST = 32'(FLASH_CYCLES - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [2:0]  ROW_HOME   = 3'd3;
    localparam logic [2:0]  ROW_BOTTOM = 3'd6;

    logic [1:0]  r_state;
    logic [31:0] r_tick;
    logic [31:0] r_flash;
    logic [2:0]  r_player_row;
    logic [7:0]  r_score;
    logic [1:0]  r_lives;
    logic        r_scroll_en;
    logic        r_board_clear;

    logic [1:0]  w_state_nx;
    logic [31:0] w_tick_nx;
    logic [31:0] w_flash_nx;
    logic [2:0]  w_row_nx;
    logic [7:0]  w_score_nx;
    logic [1:0]  w_lives_nx;
    logic        w_clear_nx;
    logic        w_scroll_nx;
    logic [2:0]  w_row_below;
    logic        w_collision;
    logic        w_tick_last;

    assign w_row_below = r_player_row + 3'd1;
    assign w_collision = (r_state == S_PLAY) &&
                         (obstacle_col[r_player_row] || obstacle_col[w_row_below]);
    assign w_tick_last = (r_tick == TICK_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        w_state_nx = r_state;
        w_tick_nx  = r_tick;
        w_flash_nx = r_flash;
        w_row_nx   = r_player_row;
        w_score_nx = r_score;
        w_lives_nx = r_lives;
        w_clear_nx = 1'b0;

        if (start) begin
            w_state_nx = S_PLAY;
            w_tick_nx  = '0;
            w_flash_nx = '0;
            w_row_nx   = ROW_HOME;
            w_score_nx = '0;
            w_lives_nx = LIVES_INIT;
            w_clear_nx = 1'b1;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (w_collision) begin
                        w_state_nx = S_HIT;
                        w_lives_nx = r_lives - 2'd1;
                        w_flash_nx = '0;
                    end else begin
                        w_tick_nx = w_tick_last ? '0 : r_tick + 32'd1;
                        if (w_tick_last && (r_score != 8'hFF))
                            w_score_nx = r_score + 8'd1;
                        if (up_req && !down_req && (r_player_row != 3'd0))
                            w_row_nx = r_player_row - 3'd1;
                        else if (down_req && !up_req && (r_player_row != ROW_BOTTOM))
                            w_row_nx = r_player_row + 3'd1;
                    end
                end
                S_HIT: begin
                    if (r_flash == FLASH_LAST) begin
                        if (r_lives == 2'd0) begin
                            w_state_nx = S_OVER;
                        end else begin
                            w_state_nx = S_PLAY;
                            w_tick_nx  = '0;
                            w_row_nx   = ROW_HOME;
                            w_clear_nx = 1'b1;
                        end
                    end else begin
                        w_flash_nx = r_flash + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // scroll_en is registered yet must coincide with the cycle the counter sits at its last value.
    assign w_scroll_nx = (w_state_nx == S_PLAY) && (w_tick_nx == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_flash       <= '0;
            r_player_row  <= ROW_HOME;
            r_score       <= '0;
            r_lives       <= LIVES_INIT;
            r_scroll_en   <= 1'b0;
            r_board_clear <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state       <= w_state_nx;
            r_tick        <= w_tick_nx;
            r_flash       <= w_flash_nx;
            r_player_row  <= w_row_nx;
            r_score       <= w_score_nx;
            r_lives       <= w_lives_nx;
            r_scroll_en   <= w_scroll_nx;
            r_board_clear <= w_clear_nx;
        end
    end

    assign state       = r_state;
    assign blank       = (r_state == S_HIT);
    assign game_over   = (r_state == S_OVER);
    assign scroll_en   = r_scroll_en;
    assign board_clear = r_board_clear;
    assign player_row  = r_player_row;
    assign score       = r_score;
    assign lives       = r_lives;

endmodule

// File: tb/tb_dot_game_sequencer.sv
// Self-checking bench for dot_game_sequencer: behavioural game model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dot_game_sequencer;

    localparam int TD = 4;
    localparam int FC = 3;
    localparam int NL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       up_req = 1'b0;
    logic       down_req = 1'b0;
    logic [7:0] obstacle_col = 8'h00;
    logic       scroll_en;
    logic       board_clear;
    logic [2:0] player_row;
    logic       blank;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic [1:0] state;

    int n_cmp = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;

    dot_game_sequencer #(.TICK_DIV(TD), .FLASH_CYCLES(FC), .LIVES(NL)) dut (
        .clk(clk), .rst(rst), .start(start), .up_req(up_req), .down_req(down_req),
        .obstacle_col(obstacle_col), .scroll_en(scroll_en), .board_clear(board_clear),
        .player_row(player_row), .blank(blank), .score(score), .lives(lives),
        .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: modes 0 idle, 1 play, 2 hit, 3 over; phase = cycles since entering play.
    int   m_mode = 0, m_row = 3, m_score = 0, m_lives = NL, m_phase = 0, m_hit_left = 0;
    logic m_clear = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0; m_row <= 3; m_score <= 0; m_lives <= NL;
            m_phase <= 0; m_hit_left <= 0; m_clear <= 1'b0;
        end else begin
            m_clear <= 1'b0;
            if (start) begin
                m_mode <= 1; m_score <= 0; m_lives <= NL; m_row <= 3;
                m_phase <= 0; m_clear <= 1'b1;
            end else if (m_mode == 1) begin
                if (obstacle_col[m_row] || obstacle_col[m_row + 1]) begin
                    m_mode <= 2; m_lives <= m_lives - 1; m_hit_left <= FC;
                end else begin
                    if (m_phase % TD == TD - 1)
                        m_score <= (m_score >= 255) ? 255 : m_score + 1;
                    if (up_req && !down_req)
                        m_row <= (m_row == 0) ? 0 : m_row - 1;
                    else if (down_req && !up_req)
                        m_row <= (m_row == 6) ? 6 : m_row + 1;
                    m_phase <= m_phase + 1;
                end
            end else if (m_mode == 2) begin
                if (m_hit_left == 1) begin
                    if (m_lives == 0) m_mode <= 3;
                    else begin
                        m_mode <= 1; m_phase <= 0; m_row <= 3; m_clear <= 1'b1;
                    end
                end else begin
                    m_hit_left <= m_hit_left - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst) begin
            check("state",       32'(state),       32'(m_mode));
            check("scroll_en",   32'(scroll_en),   32'((m_mode == 1) && (m_phase % TD == TD - 1)));
            check("board_clear", 32'(board_clear), 32'(m_clear));
            check("player_row",  32'(player_row),  32'(m_row));
            check("blank",       32'(blank),       32'(m_mode == 2));
            check("score",       32'(score),       32'(m_score));
            check("lives",       32'(lives),       32'(m_lives));
            check("game_over",   32'(game_over),   32'(m_mode == 3));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_move(input logic up, input logic down);
        up_req = up; down_req = down; step(); up_req = 1'b0; down_req = 1'b0;
    endtask

    int scroll_cnt;
    int first_scroll;
    logic got;
    int exp_rows[5] = '{2, 1, 0, 0, 0};

    initial begin
        repeat (3) step();
        rst = 1'b1;
        cmp_en = 1'b1;
        step();
        check("rst_state", 32'(state), 0);
        check("rst_row", 32'(player_row), 3);
        check("rst_lives", 32'(lives), 2);
        check("rst_score", 32'(score), 0);

        // Moves in IDLE are ignored.
        pulse_move(1'b1, 1'b0);
        check("idle_move_ignored", 32'(player_row), 3);

        // Start and scroll pacing.
        pulse_start();
        check("start_clear", 32'(board_clear), 1);
        check("start_state", 32'(state), 1);
        scroll_cnt = 0;
        first_scroll = -1;
        for (int i = 0; i < 20; i++) begin
            if (scroll_en) begin
                if (first_scroll < 0) first_scroll = i;
                scroll_cnt++;
            end
            step();
        end
        check("first_scroll_cycle", 32'(first_scroll), 3);
        check("scroll_count", 32'(scroll_cnt), 5);
        check("score_after_5", 32'(score), 5);

        // Clamping at the top, conflict ignored, then back to the home row.
        for (int i = 0; i < 5; i++) begin
            pulse_move(1'b1, 1'b0);
            check("row_up", 32'(player_row), 32'(exp_rows[i]));
        end
        pulse_move(1'b1, 1'b1);
        check("row_conflict", 32'(player_row), 0);
        for (int i = 1; i <= 3; i++) begin
            pulse_move(1'b0, 1'b1);
            check("row_down", 32'(player_row), 32'(i));
        end

        // Hit with a life remaining: obstacle on the lower sprite row.
        obstacle_col = 8'h10;
        step();
        obstacle_col = 8'h00;
        check("hit_state", 32'(state), 2);
        check("hit_lives", 32'(lives), 1);
        check("hit_blank1", 32'(blank), 1);
        step(); check("hit_blank2", 32'(blank), 1);
        step(); check("hit_blank3", 32'(blank), 1);
        step();
        check("resume_state", 32'(state), 1);
        check("resume_clear", 32'(board_clear), 1);
        check("resume_row", 32'(player_row), 3);

        // Second hit ends the game.
        obstacle_col = 8'h10;
        step();
        obstacle_col = 8'h00;
        check("hit2_lives", 32'(lives), 0);
        repeat (3) step();
        check("over_state", 32'(state), 3);
        check("over_flag", 32'(game_over), 1);
        repeat (5) step();
        pulse_start();
        check("restart_state", 32'(state), 1);
        check("restart_score", 32'(score), 0);
        check("restart_lives", 32'(lives), 2);

        // Collision on a scroll cycle suppresses the score increment.
        repeat (3) step();
        check("scroll_cycle", 32'(scroll_en), 1);
        obstacle_col = 8'h08;
        step();
        obstacle_col = 8'h00;
        check("coll_on_scroll_state", 32'(state), 2);
        check("coll_on_scroll_score", 32'(score), 0);
        repeat (3) step();
        check("resume2_state", 32'(state), 1);
        check("resume2_lives", 32'(lives), 1);

        // Saturation: reach 254, then two more scrolls.
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            if (score == 8'd254) got = 1'b1;
            else step();
        end
        check("reach_254", 32'(got), 1);
        for (int k = 0; k < 2; k++) begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                if (scroll_en) got = 1'b1;
                step();
            end
            check("sat_scroll_seen", 32'(got), 1);
            check("score_saturated", 32'(score), 255);
        end

        // Reset asserted during HIT.
        obstacle_col = 8'h08;
        step();
        obstacle_col = 8'h00;
        check("pre_reset_hit", 32'(state), 2);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_blank", 32'(blank), 0);
        check("mid_rst_row", 32'(player_row), 3);
        check("mid_rst_score", 32'(score), 0);
        check("mid_rst_lives", 32'(lives), 2);
        check("mid_rst_clear", 32'(board_clear), 0);
        check("mid_rst_scroll", 32'(scroll_en), 0);
        check("mid_rst_over", 32'(game_over), 0);
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_clear", 32'(board_clear), 0);
            check("post_rst_state", 32'(state), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
